// File: rtl/avmm_copy_pkg.sv
// Shared types and default widths for the Avalon-MM copy initiator.
// Optional checksum output is enabled by the COPY_CHECKSUM_EN macro.
package avmm_copy_pkg;

    localparam int DEF_ADDR_W       = 10;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_LEN_W        = 11;
    localparam int MAX_READ_LATENCY = 4;
    localparam int LAT_CNT_W        = $clog2(MAX_READ_LATENCY + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        FINISH
    } copy_state_e;

endpackage

// File: rtl/avmm_lat_counter.sv
// Loadable down-counter; tick is high in the last cycle of a loaded count,
// so a load of N makes the owner act on the Nth edge after the load edge.
module avmm_lat_counter
    import avmm_copy_pkg::*;
#(
    parameter int CNT_W = LAT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             active_q;
    logic             active_d;

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (load) begin
            cnt_d    = load_val - CNT_W'(1);
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign tick = active_q && (cnt_q == '0);

endmodule

// File: rtl/avmm_copy_master.sv
// Avalon-MM initiator copying a block of words, one read then one write each.
// Define COPY_CHECKSUM_EN to add a running sum of copied words on checksum.
module avmm_copy_master
    import avmm_copy_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int LEN_W        = DEF_LEN_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    input  logic              waitrequest
`ifdef COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    copy_state_e       state_q;
    copy_state_e       state_d;
    logic [ADDR_W-1:0] src_ptr_q;
    logic [ADDR_W-1:0] src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q;
    logic [ADDR_W-1:0] dst_ptr_d;
    logic [ADDR_W-1:0] address_q;
    logic [ADDR_W-1:0] address_d;
    logic [LEN_W-1:0]  remain_q;
    logic [LEN_W-1:0]  remain_d;
    logic [DATA_W-1:0] writedata_q;
    logic [DATA_W-1:0] writedata_d;
    logic              busy_q;
    logic              busy_d;
    logic              done_q;
    logic              done_d;
    logic              read_q;
    logic              read_d;
    logic              write_q;
    logic              write_d;
    logic              cs_q;
    logic              cs_d;
    logic              lat_load;
    logic              lat_tick;
`ifdef COPY_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;
    logic [DATA_W-1:0] checksum_d;
`endif

    avmm_lat_counter #(
        .CNT_W(LAT_CNT_W)
    ) u_lat (
        .clk     (clk),
        .reset   (reset),
        .load    (lat_load),
        .load_val(LAT_CNT_W'(READ_LATENCY)),
        .tick    (lat_tick)
    );

    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        address_d   = address_q;
        remain_d    = remain_q;
        writedata_d = writedata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        read_d      = read_q;
        write_d     = write_q;
        cs_d        = cs_q;
        lat_load    = 1'b0;
`ifdef COPY_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_ptr_d = src_addr;
                    dst_ptr_d = dst_addr;
                    remain_d  = length;
`ifdef COPY_CHECKSUM_EN
                    checksum_d = '0;
`endif
                    if (length != '0) begin
                        busy_d    = 1'b1;
                        read_d    = 1'b1;
                        cs_d      = 1'b1;
                        address_d = src_addr;
                        state_d   = RD_REQ;
                    end else begin
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end
                end
            end
            RD_REQ: begin
                if (!waitrequest) begin
                    read_d   = 1'b0;
                    cs_d     = 1'b0;
                    lat_load = 1'b1;
                    state_d  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_tick) begin
                    writedata_d = readdata;
`ifdef COPY_CHECKSUM_EN
                    checksum_d  = checksum_q + readdata;
`endif
                    write_d     = 1'b1;
                    cs_d        = 1'b1;
                    address_d   = dst_ptr_q;
                    state_d     = WR_REQ;
                end
            end
            WR_REQ: begin
                if (!waitrequest) begin
                    write_d   = 1'b0;
                    src_ptr_d = src_ptr_q + ADDR_W'(1);
                    dst_ptr_d = dst_ptr_q + ADDR_W'(1);
                    remain_d  = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        cs_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        read_d    = 1'b1;
                        address_d = src_ptr_q + ADDR_W'(1);
                        state_d   = RD_REQ;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            address_q   <= '0;
            remain_q    <= '0;
            writedata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            cs_q        <= 1'b0;
`ifdef COPY_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            address_q   <= address_d;
            remain_q    <= remain_d;
            writedata_q <= writedata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            read_q      <= read_d;
            write_q     <= write_d;
            cs_q        <= cs_d;
`ifdef COPY_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign address    = address_q;
    assign chipselect = cs_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
`ifdef COPY_CHECKSUM_EN
    assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_avmm_copy_master.sv
// Bench for avmm_copy_master: memory slave model plus read/write scoreboard.
// Define COPY_CHECKSUM_EN to also exercise the checksum output.
module tb_avmm_copy_master;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LW = 11;
    localparam int HW = AW + 2 + DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] length;
    logic          busy;
    logic          done;
    logic [AW-1:0] address;
    logic          chipselect;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;
    logic          waitrequest;
`ifdef COPY_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    avmm_copy_master dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .waitrequest(waitrequest)
`ifdef COPY_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    // slave memory with one cycle of read latency
    logic [DW-1:0] mem [1024];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] rd_q;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (write && !waitrequest) mem[address] <= writedata;
        rd_q <= mem[address];
    end
    assign readdata = rd_q;

    logic [DW-1:0]    model [1024];
    logic [AW-1:0]    exp_rd [$];
    logic [AW+DW-1:0] exp_wr [$];
    logic [DW-1:0]    exp_sum;
    int pass_cnt = 0;
    int total_cnt = 0;
    int r_cycles, r_nrd, r_nwr;
    bit r_done;
    logic r_busy1, r_busy_done;

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        model[a] = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic push_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                             input int n);
        logic [AW-1:0] a, b;
        logic [DW-1:0] v;
        exp_sum = '0;
        for (int i = 0; i < n; i++) begin
            a = s + AW'(i);
            b = d + AW'(i);
            v = model[a];
            exp_rd.push_back(a);
            exp_wr.push_back({b, v});
            model[b] = v;
            exp_sum = exp_sum + v;
        end
    endtask

    task automatic launch(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [LW-1:0] n);
        @(negedge clk);
        src_addr = s; dst_addr = d; length = n; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_copy(input int budget, input int stall_rd,
                            input int stall_wr, input int inj_at);
        int stall;
        logic [HW-1:0]    held;
        logic [AW-1:0]    ea;
        logic [AW+DW-1:0] ew;
        stall = 0; held = '0;
        r_cycles = 0; r_nrd = 0; r_nwr = 0; r_done = 0;
        r_busy1 = 1'b0; r_busy_done = 1'b1;
        while (!r_done && r_cycles < budget) begin
            @(negedge clk);
            r_cycles++;
            if (r_cycles == 1) r_busy1 = busy;
            if (inj_at != 0 && r_cycles == inj_at) begin
                start = 1'b1; src_addr = 10'h300;
                dst_addr = 10'h380; length = 11'd2;
            end else if (inj_at != 0 && r_cycles == inj_at + 1) begin
                start = 1'b0;
            end
            if (done) begin
                r_done = 1;
                r_busy_done = busy;
            end
            if (waitrequest) begin
                total_cnt++;
                if ({address, read, write, writedata} !== held)
                    $display("FAIL stall_hold got=%h required=%h",
                             {address, read, write, writedata}, held);
                else pass_cnt++;
                stall--;
                if (stall == 0) waitrequest = 1'b0;
            end else if ((read && r_nrd + 1 == stall_rd) ||
                         (write && r_nwr + 1 == stall_wr)) begin
                waitrequest = 1'b1;
                stall = 3;
                held = {address, read, write, writedata};
            end
            if (read && !waitrequest) begin
                total_cnt++;
                if (exp_rd.size() == 0) begin
                    $display("FAIL rd_extra addr=%h required none", address);
                end else begin
                    ea = exp_rd.pop_front();
                    if (address !== ea || chipselect !== 1'b1)
                        $display("FAIL rd_addr got=%h cs=%b required=%h cs=1",
                                 address, chipselect, ea);
                    else pass_cnt++;
                end
                r_nrd++;
            end
            if (write && !waitrequest) begin
                total_cnt++;
                if (exp_wr.size() == 0) begin
                    $display("FAIL wr_extra addr=%h data=%h required none",
                             address, writedata);
                end else begin
                    ew = exp_wr.pop_front();
                    if ({address, writedata} !== ew || chipselect !== 1'b1)
                        $display("FAIL wr got=%h cs=%b required=%h cs=1",
                                 {address, writedata}, chipselect, ew);
                    else pass_cnt++;
                end
                r_nwr++;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({busy, done, read, write, chipselect} !== 5'b0)
            $display("FAIL reset_ctrl got=%b required=00000",
                     {busy, done, read, write, chipselect});
        else pass_cnt++;
        total_cnt++;
        if (address !== '0 || writedata !== '0)
            $display("FAIL reset_bus got=%h/%h required=0/0",
                     address, writedata);
        else pass_cnt++;
`ifdef COPY_CHECKSUM_EN
        total_cnt++;
        if (checksum !== '0)
            $display("FAIL reset_sum got=%h required=0", checksum);
        else pass_cnt++;
`endif
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_copy_basic;
        for (int i = 0; i < 4; i++) poke(AW'(i), 32'hA0 + i);
        push_copy(10'h000, 10'h100, 4);
        launch(10'h000, 10'h100, 11'd4);
        run_copy(60, 0, 0, 0);
        total_cnt++;
        if (!r_done || r_cycles != 13)
            $display("FAIL basic_latency got=%0d done=%0d required=13",
                     r_cycles, r_done);
        else pass_cnt++;
        total_cnt++;
        if (r_nrd != 4 || r_nwr != 4)
            $display("FAIL basic_count got=%0d/%0d required=4/4",
                     r_nrd, r_nwr);
        else pass_cnt++;
        total_cnt++;
        if (r_busy1 !== 1'b1 || r_busy_done !== 1'b0)
            $display("FAIL basic_busy got=%b/%b required=1/0",
                     r_busy1, r_busy_done);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0)
            $display("FAIL basic_done_pulse got=%b required=0", done);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (mem[10'h100 + i] !== 32'hA0 + i)
                $display("FAIL basic_mem[%0d] got=%h required=%h",
                         i, mem[10'h100 + i], 32'hA0 + i);
            else pass_cnt++;
        end
    endtask

    task automatic test_zero_length;
        launch(10'h060, 10'h160, 11'd0);
        run_copy(10, 0, 0, 0);
        total_cnt++;
        if (!r_done || r_cycles != 1 || r_busy1 !== 1'b0)
            $display("FAIL zero_done got=%0d done=%0d busy=%b required=1/1/0",
                     r_cycles, r_done, r_busy1);
        else pass_cnt++;
        total_cnt++;
        if (r_nrd != 0 || r_nwr != 0)
            $display("FAIL zero_bus got=%0d/%0d required=0/0", r_nrd, r_nwr);
        else pass_cnt++;
    endtask

    task automatic test_wrap;
        poke(10'h3FE, 32'h11);
        poke(10'h3FF, 32'h22);
        poke(10'h000, 32'h33);
        push_copy(10'h3FE, 10'h3FF, 3);
        launch(10'h3FE, 10'h3FF, 11'd3);
        run_copy(60, 0, 0, 0);
        total_cnt++;
        if (!r_done || r_cycles != 10)
            $display("FAIL wrap_latency got=%0d required=10", r_cycles);
        else pass_cnt++;
        total_cnt++;
        if (mem[1] !== 32'h11 || mem[0] !== 32'h11)
            $display("FAIL wrap_mem got=%h/%h required=11/11", mem[0], mem[1]);
        else pass_cnt++;
    endtask

    task automatic test_stall;
        for (int i = 0; i < 4; i++) poke(AW'(10'h010 + i), 32'h5A00 + i);
        push_copy(10'h010, 10'h110, 4);
        launch(10'h010, 10'h110, 11'd4);
        run_copy(80, 2, 2, 0);
        total_cnt++;
        if (!r_done || r_cycles != 19)
            $display("FAIL stall_latency got=%0d required=19", r_cycles);
        else pass_cnt++;
        total_cnt++;
        if (mem[10'h111] !== 32'h5A01)
            $display("FAIL stall_mem got=%h required=5a01", mem[10'h111]);
        else pass_cnt++;
    endtask

    task automatic test_start_while_busy;
        for (int i = 0; i < 8; i++) poke(AW'(10'h020 + i), 32'hC000 + i * 3);
        push_copy(10'h020, 10'h120, 8);
        launch(10'h020, 10'h120, 11'd8);
        run_copy(100, 0, 0, 5);
        total_cnt++;
        if (!r_done || r_cycles != 25 || r_nwr != 8)
            $display("FAIL busy_ignore got=%0d/%0d required=25/8",
                     r_cycles, r_nwr);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || read !== 1'b0)
            $display("FAIL busy_restart got=%b/%b required=0/0", busy, read);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int dones;
        for (int i = 0; i < 8; i++) poke(AW'(10'h030 + i), 32'hD000 + i);
        push_copy(10'h030, 10'h130, 8);
        launch(10'h030, 10'h130, 11'd8);
        run_copy(7, 0, 0, 0);
        total_cnt++;
        if (r_nwr != 2 || r_done)
            $display("FAIL mid_progress got=%0d required=2", r_nwr);
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({read, write, chipselect, busy, done} !== 5'b0)
            $display("FAIL mid_reset got=%b required=00000",
                     {read, write, chipselect, busy, done});
        else pass_cnt++;
        reset = 1'b0;
        exp_rd.delete();
        exp_wr.delete();
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || read || write) dones++;
        end
        total_cnt++;
        if (dones != 0)
            $display("FAIL mid_quiet got=%0d required=0", dones);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) poke(AW'(10'h040 + i), 32'hE000 + i);
        push_copy(10'h040, 10'h140, 3);
        launch(10'h040, 10'h140, 11'd3);
        run_copy(60, 0, 0, 0);
        total_cnt++;
        if (!r_done || r_cycles != 10 || mem[10'h142] !== 32'hE002)
            $display("FAIL mid_fresh got=%0d/%h required=10/e002",
                     r_cycles, mem[10'h142]);
        else pass_cnt++;
    endtask

`ifdef COPY_CHECKSUM_EN
    task automatic test_checksum;
        poke(10'h050, 32'h1);
        poke(10'h051, 32'h2);
        poke(10'h052, 32'hFFFF_FFFF);
        push_copy(10'h050, 10'h150, 3);
        launch(10'h050, 10'h150, 11'd3);
        run_copy(60, 0, 0, 0);
        total_cnt++;
        if (checksum !== exp_sum || checksum !== 32'h2)
            $display("FAIL sum got=%h required=00000002", checksum);
        else pass_cnt++;
        repeat (5) @(negedge clk);
        total_cnt++;
        if (checksum !== 32'h2)
            $display("FAIL sum_hold got=%h required=00000002", checksum);
        else pass_cnt++;
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; waitrequest = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        exp_sum = '0;
        for (int i = 0; i < 1024; i++) model[i] = '0;
        test_reset();
        test_copy_basic();
        test_zero_length();
        test_wrap();
        test_stall();
        test_start_while_busy();
        test_reset_mid();
`ifdef COPY_CHECKSUM_EN
        test_checksum();
`endif
        total_cnt++;
        if (exp_rd.size() != 0 || exp_wr.size() != 0)
            $display("FAIL sb_leftover got=%0d/%0d required=0/0",
                     exp_rd.size(), exp_wr.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/avmm_copy_master.md
Name: avmm_copy_master

Overview:
- Avalon-MM initiator that copies a block of 32-bit words from one word address range to another over a single master port.
- Targets word-addressed memory-mapped slaves such as the on-chip buffer IP. Slaves may have a fixed read latency and may use optional waitrequest stalls.
- Sits between a control source (Nios-side control register or test FSM) and the buffer slave's Avalon-MM port.

Parameters:
- ADDR_W, 10, word-address width of the master port.
- DATA_W, 32, data width.
- LEN_W, 11, width of the transfer length; max length is 2^ADDR_W.
- READ_LATENCY, 1, fixed cycles from accepted read to valid readdata; legal range 1..4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; launches a copy when idle.
- src_addr  in  ADDR_W  first source word address; sampled on accepted start.
- dst_addr  in  ADDR_W  first destination word address; sampled on accepted start.
- length  in  LEN_W  number of words to copy; sampled on accepted start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when the copy completes.
- address  out  ADDR_W  Avalon-MM address.
- chipselect  out  1  high whenever read or write is high.
- read  out  1  read request.
- write  out  1  write request.
- writedata  out  DATA_W  write data.
- readdata  in  DATA_W  read data, valid READ_LATENCY cycles after an accepted read.
- waitrequest  in  1  slave stall; tie to 0 for slaves without stalls.

Behaviour:
- Reset values: busy=0, done=0, read=0, write=0, chipselect=0, address=0, writedata=0. All outputs are registered.
- States:
  - IDLE: waits for start.
  - RD_REQ: issues a read.
  - RD_WAIT: counts out READ_LATENCY.
  - WR_REQ: issues a write.
  - FINISH: signals completion.
- IDLE:
  - start=1 with length!=0: latch src, dst and length; busy=1; go to RD_REQ.
  - start=1 with length==0: go to FINISH with no bus activity.
- RD_REQ: read=1, address=src pointer. A request is accepted in the cycle where read=1 and waitrequest=0; on acceptance go to RD_WAIT and deassert read the next cycle.
- RD_WAIT: a latency counter runs from acceptance. readdata is captured into writedata exactly READ_LATENCY cycles after the accept edge, then go to WR_REQ.
- WR_REQ: write=1, address=dst pointer, writedata held. On acceptance (waitrequest=0):
  - increment both pointers modulo 2^ADDR_W; wrap 1023->0 is legal and silent;
  - decrement the remaining count;
  - go to RD_REQ if the count is still nonzero, otherwise to FINISH.
- FINISH: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- Throughput with waitrequest=0: 2+READ_LATENCY cycles per word.
- While waitrequest=1: address, read, write and writedata hold stable.
- start while busy or in FINISH: ignored; no restart, inputs not resampled.
- Overlapping ranges: no hazard handling; data is copied strictly ascending, word by word.
- length > 2^ADDR_W: undefined; the bench must not drive it.
- Reset asserted mid-copy: on the next edge return to IDLE, drop read/write/chipselect, and produce no done pulse.

Optional Feature:
- Macro COPY_CHECKSUM_EN.
- When defined:
  - adds output checksum [DATA_W-1:0];
  - checksum clears on accepted start;
  - adds each captured readdata word modulo 2^DATA_W;
  - holds its value after done until the next start;
  - reset value is 0.
- When undefined: the port and adder are absent, and behaviour is otherwise identical.

Decomposition:
- Package avmm_copy_pkg:
  - state enum (IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH);
  - default widths ADDR_W/DATA_W/LEN_W;
  - MAX_READ_LATENCY=4.
- Sub-module avmm_lat_counter: loadable down-counter that asserts its tick when the READ_LATENCY count expires. It is reusable by future Avalon initiators.

Test Plan:
- Copy basic: preload slave mem[0..3]=0xA0..0xA3; src=0, dst=0x100, len=4 -> mem[0x100..0x103]=0xA0..0xA3; done after 4*(2+1)+1 cycles; exactly 4 reads and 4 writes.
- Zero length: start with len=0 -> done one cycle later; read and write never asserted.
- Wrap: src=0x3FE, dst=0x3FF, len=3 -> reads 0x3FE, 0x3FF, 0x000 and writes 0x3FF, 0x000, 0x001.
- Waitrequest stall: hold waitrequest=1 for 3 cycles on the 2nd read and 2nd write -> signals stable while stalled; data correct; total cycles +6.
- Start while busy, and reset mid-copy:
  - pulse start with new addresses during a len=8 copy -> ignored;
  - assert reset after 2 writes -> next cycle read=write=0, busy=0, no done; a subsequent fresh copy is correct.
- COPY_CHECKSUM_EN: copy words 1,2,0xFFFFFFFF -> checksum=0x00000002, held after done.
